// File: rtl/timer_pkg.sv
// Shared types and helpers for the interval timer bank.
// Channel FSM states, run modes and a millisecond-to-tick conversion.
package timer_pkg;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_RUN     = 2'd1,
        T_EXPIRED = 2'd2
    } tmr_state_e;

    typedef enum logic {
        T_ONESHOT  = 1'b0,
        T_PERIODIC = 1'b1
    } tmr_mode_e;

    function automatic longint unsigned ticks_from_ms(input longint unsigned ms,
                                                      input longint unsigned clk_hz);
        return (ms * clk_hz) / 64'd1000;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One interval timer: run/expire FSM, up-counter, and its own period/mode registers.
//  state     | meaning
//  T_IDLE    | stopped, counter 0
//  T_RUN     | counting while enable is high
//  T_EXPIRED | one-shot finished, counter parked at period-1
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned DEFAULT_TICKS = 200_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             clear_done,
    output logic             done_pulse,
    output logic             done_flag,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    tmr_state_e       r_state;
    tmr_mode_e        r_mode;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic             r_done_pulse;
    logic             r_done_flag;

    logic             w_terminal;
    logic [CNT_W-1:0] w_period_wr;

    // Compare against the stored period so a shrink below the current count fires at once.
    assign w_terminal  = (r_state == T_RUN) && enable && (r_count >= r_period - CNT_W'(1));
    assign w_period_wr = (cfg_period == '0) ? CNT_W'(1) : cfg_period;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= T_IDLE;
            r_mode       <= T_ONESHOT;
            r_count      <= '0;
            r_period     <= CNT_W'(DEFAULT_TICKS);
            r_done_pulse <= 1'b0;
            r_done_flag  <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            if (clear_done) begin
                r_done_flag <= 1'b0;
            end
            if (stop) begin
                r_state <= T_IDLE;
                r_count <= '0;
            end else if (start) begin
                r_state <= T_RUN;
                r_count <= '0;
                if (w_terminal) begin
                    r_done_pulse <= 1'b1;
                    r_done_flag  <= 1'b1;
                end
            end else if (w_terminal) begin
                r_done_pulse <= 1'b1;
                r_done_flag  <= 1'b1;
                if (r_mode == T_PERIODIC) begin
                    r_count <= '0;
                end else begin
                    r_state <= T_EXPIRED;
                    r_count <= r_period - CNT_W'(1);
                end
            end else if ((r_state == T_RUN) && enable) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (cfg_we) begin
                r_period <= w_period_wr;
                r_mode   <= tmr_mode_e'(cfg_mode);
            end
        end
    end

    assign done_pulse = r_done_pulse;
    assign done_flag  = r_done_flag;
    assign busy       = (r_state == T_RUN);
    assign count      = r_count;

endmodule

// File: rtl/interval_timer_bank.sv
// Bank of independent interval timers sharing one configuration port.
// Decodes cfg_ch into per-channel write strobes and registers the selected counter for readback.
module interval_timer_bank
    import timer_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 28,
    parameter int unsigned DEFAULT_TICKS = 32'(ticks_from_ms(64'd2000, 64'(CLK_HZ))),
    localparam int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] start,
    input  logic [NUM_CH-1:0] stop,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] clear_done,
    output logic [NUM_CH-1:0] done_pulse,
    output logic [NUM_CH-1:0] done_flag,
    output logic [NUM_CH-1:0] busy,
    output logic [CNT_W-1:0]  rd_count
);

    logic [CNT_W-1:0] w_counts [NUM_CH];
    logic [CNT_W-1:0] r_rd_count;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_ch_we;
        assign w_ch_we = cfg_we && (cfg_ch == CH_W'(g));

        timer_channel #(
            .CNT_W         (CNT_W),
            .DEFAULT_TICKS (DEFAULT_TICKS)
        ) u_channel (
            .clock      (clock),
            .reset      (reset),
            .cfg_we     (w_ch_we),
            .cfg_period (cfg_period),
            .cfg_mode   (cfg_mode),
            .start      (start[g]),
            .stop       (stop[g]),
            .enable     (enable[g]),
            .clear_done (clear_done[g]),
            .done_pulse (done_pulse[g]),
            .done_flag  (done_flag[g]),
            .busy       (busy[g]),
            .count      (w_counts[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_count <= '0;
        end else begin
            r_rd_count <= w_counts[cfg_ch];
        end
    end

    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_interval_timer_bank.sv
// Randomized and directed bench for interval_timer_bank against a per-channel behavioural model.
module tb_interval_timer_bank;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DEF    = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic              cfg_mode;
    logic [NUM_CH-1:0] start, stop, enable, clear_done;
    logic [NUM_CH-1:0] done_pulse, done_flag, busy;
    logic [CNT_W-1:0]  rd_count;

    interval_timer_bank #(
        .CLK_HZ        (100_000_000),
        .NUM_CH        (NUM_CH),
        .CNT_W         (CNT_W),
        .DEFAULT_TICKS (DEF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .enable     (enable),
        .clear_done (clear_done),
        .done_pulse (done_pulse),
        .done_flag  (done_flag),
        .busy       (busy),
        .rd_count   (rd_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model: elapsed-tick count, period, periodic flag, and activity (0 stopped, 1 running, 2 finished)
    int m_cnt  [NUM_CH];
    int m_per  [NUM_CH];
    int m_per_mode [NUM_CH];
    int m_act  [NUM_CH];
    int m_flag [NUM_CH];
    int m_pls  [NUM_CH];
    int m_rd;

    function automatic bit m_term(input int ch);
        return (m_act[ch] == 1) && (enable[ch] == 1'b1) && (m_cnt[ch] >= m_per[ch] - 1);
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt[c] = 0; m_per[c] = DEF; m_per_mode[c] = 0;
                m_act[c] = 0; m_flag[c] = 0; m_pls[c] = 0;
            end
            m_rd = 0;
        end else begin
            m_rd = m_cnt[cfg_ch];
            for (int c = 0; c < NUM_CH; c++) begin
                bit t;
                int p;
                t = m_term(c);
                p = 0;
                if (stop[c]) begin
                    m_act[c] = 0; m_cnt[c] = 0;
                end else if (start[c]) begin
                    p = t ? 1 : 0;
                    m_act[c] = 1; m_cnt[c] = 0;
                end else if (t) begin
                    p = 1;
                    if (m_per_mode[c] == 1) m_cnt[c] = 0;
                    else begin m_act[c] = 2; m_cnt[c] = m_per[c] - 1; end
                end else if (m_act[c] == 1 && enable[c]) begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
                m_pls[c]  = p;
                m_flag[c] = p ? 1 : (clear_done[c] ? 0 : m_flag[c]);
                if (cfg_we && cfg_ch == 2'(c)) begin
                    m_per[c] = (cfg_period == 0) ? 1 : int'(cfg_period);
                    m_per_mode[c] = int'(cfg_mode);
                end
            end
        end
    endtask

    task automatic step();
        logic [NUM_CH-1:0] e_p, e_f, e_b;
        model_edge();
        for (int c = 0; c < NUM_CH; c++) begin
            e_p[c] = (m_pls[c] != 0);
            e_f[c] = (m_flag[c] != 0);
            e_b[c] = (m_act[c] == 1);
        end
        @(posedge clock);
        #1;
        check_val("done_pulse", 32'(done_pulse), 32'(e_p));
        check_val("done_flag",  32'(done_flag),  32'(e_f));
        check_val("busy",       32'(busy),       32'(e_b));
        check_val("rd_count",   32'(rd_count),   m_rd);
        start = '0; stop = '0; clear_done = '0; cfg_we = 1'b0;
    endtask

    task automatic cfg(input int ch, input int per, input int mode);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = CNT_W'(per); cfg_mode = mode[0];
    endtask

    task automatic run_to_term(input int ch);
        int g;
        g = 0;
        while (!m_term(ch) && g < 60) begin
            step();
            g++;
        end
        check_val("term_reached", 32'(g < 60), 1);
    endtask

    int lat, first, npulse;

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_mode = 1'b0;
        start = '0; stop = '0; enable = '0; clear_done = '0;
        step(); step();
        check_val("reset_busy", 32'(busy), 0);
        reset = 1'b0;

        // one-shot at default period on ch0
        enable = 4'b0001; start[0] = 1'b1; step();
        npulse = 0; first = 0; lat = 0;
        repeat (14) begin
            step(); lat++;
            if (done_pulse[0]) begin npulse++; if (npulse == 1) first = lat; end
        end
        check_val("ch0_latency", first, DEF);
        check_val("ch0_pulses", npulse, 1);
        check_val("ch0_flag_held", 32'(done_flag[0]), 1);
        clear_done[0] = 1'b1; step();
        check_val("ch0_flag_cleared", 32'(done_flag[0]), 0);

        // periodic period 5 on ch1
        cfg(1, 5, 1); step();
        start[1] = 1'b1; enable[1] = 1'b1; step();
        npulse = 0;
        repeat (20) begin step(); if (done_pulse[1]) npulse++; end
        check_val("ch1_pulses", npulse, 4);
        stop[1] = 1'b1; step();

        // ch2 period 8 with a 4-cycle pause
        cfg(2, 8, 0); step();
        cfg_ch = 2'd2;
        start[2] = 1'b1; enable[2] = 1'b1; step();
        first = 0;
        for (int k = 1; k <= 16; k++) begin
            enable[2] = !(k >= 3 && k <= 6);
            step();
            if (done_pulse[2] && first == 0) first = k;
        end
        check_val("ch2_latency", first, 12);
        enable[2] = 1'b1;

        // ch3 shrink mid-run, then period 0 periodic
        cfg_ch = 2'd3; start[3] = 1'b1; enable[3] = 1'b1; step();
        repeat (7) step();
        cfg(3, 4, 0); step();
        step();
        check_val("ch3_shrink_pulse", 32'(done_pulse[3]), 1);
        cfg(3, 0, 1); step();
        start[3] = 1'b1; step();
        npulse = 0;
        repeat (6) begin step(); if (done_pulse[3]) npulse++; end
        check_val("ch3_every_cycle", npulse, 6);
        stop[3] = 1'b1; step();

        // same-cycle collisions on ch0
        cfg(0, 3, 0); step();
        enable[0] = 1'b1; start[0] = 1'b1; step();
        run_to_term(0);
        clear_done[0] = 1'b1; step();
        check_val("clr_vs_term_flag", 32'(done_flag[0]), 1);
        clear_done[0] = 1'b1; cfg(0, 3, 1); step();
        start[0] = 1'b1; step();
        run_to_term(0);
        stop[0] = 1'b1; step();
        check_val("stop_vs_term_pulse", 32'(done_pulse[0]), 0);
        check_val("stop_vs_term_busy", 32'(busy[0]), 0);
        start[0] = 1'b1; step();
        run_to_term(0);
        start[0] = 1'b1; step();
        check_val("start_vs_term_pulse", 32'(done_pulse[0]), 1);
        check_val("start_vs_term_busy", 32'(busy[0]), 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                start[c]      = ($urandom_range(0, 19) == 0);
                stop[c]       = ($urandom_range(0, 39) == 0);
                clear_done[c] = ($urandom_range(0, 15) == 0);
                enable[c]     = ($urandom_range(0, 3) != 0);
            end
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_we = ($urandom_range(0, 11) == 0);
            cfg_period = CNT_W'($urandom_range(0, 14));
            cfg_mode = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        // reset mid-run restores default periods
        enable = '1; start = '1; step();
        repeat (4) step();
        reset = 1'b1; step();
        check_val("rst_outputs", 32'({done_pulse, done_flag, busy}), 0);
        check_val("rst_rd_count", 32'(rd_count), 0);
        reset = 1'b0;
        start = '1; step();
        first = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (done_pulse[1] && first == 0) first = k;
        end
        check_val("rst_default_period", first, DEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
